// File: rtl/nimplus_pkg.sv
// Shared constants and types for the NIM+ DAC programming path.
package nimplus_pkg;

  localparam int DAC_WORD_BITS = 24;

  localparam logic [31:0] DAC_ADDR_DEF  = 32'h0000_0010;
  localparam logic [31:0] CTRL_ADDR_DEF = 32'h0000_0011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD
  } dac_state_t;

endpackage

// File: rtl/dac_prog_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO; rdata is valid whenever !empty.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 level_q, level_d;
  logic                        wr_en, rd_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dac_prog_ctrl.sv
// Queues DAC command words from the Ethernet register bus and shifts them out
// MSB first on the NIM+ threshold DAC serial interface.
module dac_prog_ctrl
  import nimplus_pkg::*;
#(
  parameter logic [31:0] DAC_ADDR   = DAC_ADDR_DEF,
  parameter logic [31:0] CTRL_ADDR  = CTRL_ADDR_DEF,
  parameter int          CLK_DIV    = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          MASTER_CLK,
  input  logic                          reset_in,
  input  logic                          rx_wren,
  input  logic [31:0]                   rx_addr,
  input  logic [63:0]                   rx_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   words_sent,
  output logic                          DAC_SER_CLK,
  output logic                          DAC_NSYNC,
  output logic                          DAC_DIN
);

  localparam int DIVW = $clog2(2*CLK_DIV) + 1;
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HOLD = DIVW'(2*CLK_DIV - 1);
  localparam logic [4:0]      LAST_BIT = 5'(DAC_WORD_BITS - 1);

  dac_state_t                 state_q, state_d;
  logic [DIVW-1:0]            div_q, div_d;
  logic [4:0]                 bit_q, bit_d;
  logic [DAC_WORD_BITS-1:0]   shreg_q, shreg_d;
  logic                       sclk_q, sclk_d;
  logic                       nsync_q, nsync_d;
  logic                       ovf_q, ovf_d;
  logic [15:0]                words_sent_q, words_sent_d;

  logic                       wr_dac, wr_ctrl, drop;
  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DAC_WORD_BITS-1:0]   fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_lvl;
  logic                       unused_rx_hi;

  assign unused_rx_hi = ^rx_data[63:DAC_WORD_BITS];

  assign wr_dac    = rx_wren && (rx_addr == DAC_ADDR);
  assign wr_ctrl   = rx_wren && (rx_addr == CTRL_ADDR);
  assign drop      = wr_dac && fifo_full && !fifo_pop;
  assign fifo_push = wr_dac && !drop;

  sync_fifo #(
    .WIDTH (DAC_WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MASTER_CLK),
    .rst   (reset_in),
    .push  (fifo_push),
    .wdata (rx_data[DAC_WORD_BITS-1:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  // DIN is the shift register MSB: after 24 shifts the register is all zero,
  // so DIN naturally returns low for HOLD and IDLE.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    sclk_d       = sclk_q;
    nsync_d      = nsync_q;
    words_sent_d = words_sent_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          nsync_d  = 1'b0;
          sclk_d   = 1'b1;
          div_d    = DIV_HALF;
          bit_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (div_q == '0) begin
          div_d   = DIV_HALF;
          state_d = SHIFT_HI;
        end else div_d = div_q - 1'b1;
      end
      SHIFT_HI: begin
        if (div_q == '0) begin
          sclk_d  = 1'b0;
          div_d   = DIV_HALF;
          state_d = SHIFT_LO;
        end else div_d = div_q - 1'b1;
      end
      SHIFT_LO: begin
        if (div_q == '0) begin
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[DAC_WORD_BITS-2:0], 1'b0};
          if (bit_q == LAST_BIT) begin
            nsync_d      = 1'b1;
            words_sent_d = words_sent_q + 16'd1;
            div_d        = DIV_HOLD;
            state_d      = HOLD;
          end else begin
            bit_d   = bit_q + 5'd1;
            div_d   = DIV_HALF;
            state_d = SHIFT_HI;
          end
        end else div_d = div_q - 1'b1;
      end
      HOLD: begin
        if (div_q == '0) state_d = IDLE;
        else             div_d   = div_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_ctrl && rx_data[0]) ovf_d = 1'b0;
    if (drop)                  ovf_d = 1'b1;
  end

  always_ff @(posedge MASTER_CLK or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      sclk_q       <= 1'b1;
      nsync_q      <= 1'b1;
      ovf_q        <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      sclk_q       <= sclk_d;
      nsync_q      <= nsync_d;
      ovf_q        <= ovf_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign DAC_SER_CLK = sclk_q;
  assign DAC_NSYNC   = nsync_q;
  assign DAC_DIN     = shreg_q[DAC_WORD_BITS-1];
  assign overflow    = ovf_q;
  assign words_sent  = words_sent_q;
  assign fifo_level  = fifo_lvl;
  assign busy        = (state_q != IDLE) || (fifo_lvl != '0);

endmodule

// File: tb/tb_dac_prog_ctrl.sv
// Directed bench for dac_prog_ctrl with CLK_DIV=4, FIFO_DEPTH=4.
module tb_dac_prog_ctrl;

  localparam logic [31:0] DAC_A  = 32'h0000_0010;
  localparam logic [31:0] CTRL_A = 32'h0000_0011;

  logic        MASTER_CLK;
  logic        reset_in;
  logic        rx_wren;
  logic [31:0] rx_addr;
  logic [63:0] rx_data;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] words_sent;
  logic        DAC_SER_CLK, DAC_NSYNC, DAC_DIN;

  int n_cmp = 0;
  int n_err = 0;

  dac_prog_ctrl #(
    .DAC_ADDR   (DAC_A),
    .CTRL_ADDR  (CTRL_A),
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .MASTER_CLK  (MASTER_CLK),
    .reset_in    (reset_in),
    .rx_wren     (rx_wren),
    .rx_addr     (rx_addr),
    .rx_data     (rx_data),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .words_sent  (words_sent),
    .DAC_SER_CLK (DAC_SER_CLK),
    .DAC_NSYNC   (DAC_NSYNC),
    .DAC_DIN     (DAC_DIN)
  );

  initial MASTER_CLK = 1'b0;
  always #5 MASTER_CLK = ~MASTER_CLK;

  // Pin monitor: stamps NSYNC edges and collects the DIN value at each SCLK fall.
  int          cyc = 0;
  int          fall_q[$];
  int          rise_q[$];
  logic [23:0] cap_q[$];
  logic [23:0] cap = '0;
  int          nbits = 0;
  logic        p_sclk = 1'b1;
  logic        p_nsync = 1'b1;

  always @(negedge MASTER_CLK) begin
    if (p_nsync && !DAC_NSYNC) begin
      fall_q.push_back(cyc + 1);
      nbits <= 0;
      cap   <= '0;
    end
    if (!p_nsync && DAC_NSYNC) begin
      rise_q.push_back(cyc + 1);
      cap_q.push_back(cap);
    end
    if (p_sclk && !DAC_SER_CLK && !DAC_NSYNC) begin
      cap   <= {cap[22:0], DAC_DIN};
      nbits <= nbits + 1;
    end
    p_sclk  <= DAC_SER_CLK;
    p_nsync <= DAC_NSYNC;
    cyc     <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge MASTER_CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    rx_wren = 1'b1;
    rx_addr = a;
    rx_data = d;
    tick();
    rx_wren = 1'b0;
    rx_addr = '0;
    rx_data = '0;
  endtask

  task automatic wait_rises(input int n, input int bound, input string tag);
    int k = 0;
    while (rise_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk(tag, rise_q.size(), n);
  endtask

  task automatic clear_mon();
    fall_q.delete();
    rise_q.delete();
    cap_q.delete();
  endtask

  logic [23:0] w6 [6];
  int t0;

  initial begin
    w6[0] = 24'h123456; w6[1] = 24'hFEDCBA; w6[2] = 24'h800001;
    w6[3] = 24'h0F0F0F; w6[4] = 24'h7FFFFE; w6[5] = 24'hDEAD00;
    reset_in = 1'b1;
    rx_wren  = 1'b0;
    rx_addr  = '0;
    rx_data  = '0;
    tick(3);
    chk("rst_sclk",  DAC_SER_CLK, 1);
    chk("rst_nsync", DAC_NSYNC,   1);
    chk("rst_din",   DAC_DIN,     0);
    chk("rst_busy",  busy,        0);
    chk("rst_level", fifo_level,  0);
    chk("rst_ovf",   overflow,    0);
    chk("rst_words", words_sent,  0);
    reset_in = 1'b0;
    tick(2);

    // Single frame
    t0 = cyc;
    wr(DAC_A, 64'hFFFF_FFFF_FFA5_C30F);
    chk("one_level", fifo_level, 1);
    chk("one_busy",  busy,       1);
    chk("one_nsync_still_hi", DAC_NSYNC, 1);
    wait_rises(1, 400, "one_frame_done");
    chk("one_latency", fall_q[0] - t0, 2);
    chk("one_low_len", rise_q[0] - fall_q[0], 196);
    chk("one_bits",    cap_q[0], 24'hA5C30F);
    chk("one_nbits",   nbits, 24);
    chk("one_words",   words_sent, 1);
    chk("one_din_hold", DAC_DIN, 0);
    tick(10);
    chk("one_idle_busy", busy, 0);

    // Unmapped address
    clear_mon();
    wr(32'h0000_0012, 64'h00AB_CDEF);
    tick(5);
    chk("ign_level", fifo_level, 0);
    chk("ign_busy",  busy, 0);
    chk("ign_nsync", DAC_NSYNC, 1);
    chk("ign_sclk",  DAC_SER_CLK, 1);
    chk("ign_frames", fall_q.size(), 0);

    // Six back-to-back writes: one pops, four queue, one drops
    clear_mon();
    for (int i = 0; i < 6; i++) wr(DAC_A, {40'h0, w6[i]});
    chk("burst_ovf",   overflow,   1);
    chk("burst_level", fifo_level, 4);
    wait_rises(5, 5*205 + 100, "burst_frames_done");
    for (int i = 0; i < 5; i++) chk($sformatf("burst_word%0d", i), cap_q[i], w6[i]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_period%0d", i), fall_q[i+1] - fall_q[i], 205);
      chk($sformatf("burst_gap%0d", i),    fall_q[i+1] - rise_q[i], 9);
    end
    tick(20);
    chk("burst_no_sixth", fall_q.size(), 5);
    chk("burst_words", words_sent, 6);
    chk("burst_busy",  busy, 0);
    wr(CTRL_A, 64'h2);
    chk("ctrl_bit1_keeps_ovf", overflow, 1);
    wr(CTRL_A, 64'h1);
    chk("ctrl_clears_ovf", overflow, 0);

    // Push into a full FIFO on the cycle the next frame pops
    clear_mon();
    for (int i = 0; i < 5; i++) wr(DAC_A, {40'h0, w6[i]});
    chk("full_level", fifo_level, 4);
    chk("full_ovf",   overflow,   0);
    wait_rises(1, 400, "full_first_done");
    tick(8);
    wr(DAC_A, 64'h00C0_FFEE);
    chk("popush_level", fifo_level, 4);
    chk("popush_ovf",   overflow,   0);
    chk("popush_frame_start", DAC_NSYNC, 0);

    // Asynchronous reset during bit 10 of the running frame
    begin
      int k = 0;
      while (nbits < 10 && k < 200) begin
        tick();
        k++;
      end
      chk("reset_reach_bit10", nbits, 10);
    end
    #2 reset_in = 1'b1;
    #1;
    chk("arst_sclk",  DAC_SER_CLK, 1);
    chk("arst_nsync", DAC_NSYNC,   1);
    chk("arst_din",   DAC_DIN,     0);
    chk("arst_level", fifo_level,  0);
    chk("arst_busy",  busy,        0);
    chk("arst_words", words_sent,  0);
    tick();
    clear_mon();
    reset_in = 1'b0;
    tick(300);
    chk("arst_no_frames", fall_q.size(), 0);
    chk("arst_idle_busy", busy, 0);

    // Counter wrap: preload via the next-state value for one edge
    force dut.words_sent_d = 16'hFFFF;
    tick();
    release dut.words_sent_d;
    tick();
    chk("wrap_preload", words_sent, 16'hFFFF);
    clear_mon();
    wr(DAC_A, 64'h0055_AA55);
    wait_rises(1, 400, "wrap_frame_done");
    chk("wrap_word",  cap_q[0], 24'h55AA55);
    chk("wrap_zero",  words_sent, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
